// File: rtl/dart_thrower.sv
// Dart thrower: queues host coordinate pairs (or LFSR throws in auto mode), strobes each dart
// to the scoring machine and waits for the scorer to finish, with a timeout guard.
module dart_thrower #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       auto_mode_i,
  input  logic       throw_valid_i,
  input  logic [7:0] throw_x_i,
  input  logic [7:0] throw_y_i,
  output logic       throw_ready_o,
  output logic       dart_come_o,
  output logic [7:0] dart_position_x_o,
  output logic [7:0] dart_position_y_o,
  input  logic       player_1_done_i,
  input  logic       player_2_done_i,
  input  logic       game_set_i,
  output logic       busy_o,
  output logic       timeout_o,
  output logic [7:0] throw_count_o,
  output logic [2:0] fifo_count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    StIdle, StArm, StFire, StWaitDone, StGap, StStop, StError
  } state_e;

  state_e          state_q;
  logic [7:0]      mem_x_q [DEPTH];
  logic [7:0]      mem_y_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]      count_q;
  logic [7:0]      lfsr_q;
  logic [7:0]      lfsr_next;
  logic [15:0]     timer_q;
  logic            dart_come_q, timeout_q;
  logic [7:0]      pos_x_q, pos_y_q, throw_count_q;
  logic            push, pop;

  function automatic logic [7:0] sat30(input logic [7:0] v);
    return (v > 8'd30) ? 8'd30 : v;
  endfunction

  // 31 is off the board, fold it back to the centre line.
  function automatic logic [7:0] map31(input logic [4:0] v);
    return (v == 5'd31) ? 8'd15 : {3'b000, v};
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // XNOR form of x^8+x^6+x^5+x^4+1 so that the all-zero state is reachable from reset.
  assign lfsr_next = {lfsr_q[6:0], ~(lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3])};

  assign throw_ready_o = (count_q < 3'(DEPTH));
  assign push          = throw_valid_i && throw_ready_o;
  // Pop decision uses registered occupancy only; a same-cycle push is not bypassed.
  assign pop           = (state_q == StArm) && (count_q != 3'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 3'd0;
    end else begin
      if (push) begin
        mem_x_q[wr_ptr_q] <= sat30(throw_x_i);
        mem_y_q[wr_ptr_q] <= sat30(throw_y_i);
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      lfsr_q        <= LFSR_SEED;
      timer_q       <= 16'd0;
      dart_come_q   <= 1'b0;
      timeout_q     <= 1'b0;
      pos_x_q       <= 8'd0;
      pos_y_q       <= 8'd0;
      throw_count_q <= 8'd0;
    end else begin
      dart_come_q <= 1'b0;
      case (state_q)
        StIdle: if (start_i) state_q <= StArm;
        StArm: begin
          if (count_q != 3'd0) begin
            pos_x_q     <= mem_x_q[rd_ptr_q];
            pos_y_q     <= mem_y_q[rd_ptr_q];
            dart_come_q <= 1'b1;
            state_q     <= StFire;
          end else if (auto_mode_i) begin
            pos_x_q     <= map31(lfsr_q[4:0]);
            pos_y_q     <= map31(lfsr_q[7:3]);
            lfsr_q      <= lfsr_next;
            dart_come_q <= 1'b1;
            state_q     <= StFire;
          end
        end
        StFire: begin
          timer_q <= 16'd0;
          state_q <= StWaitDone;
        end
        StWaitDone: begin
          timer_q <= timer_q + 16'd1;
          if (player_1_done_i || player_2_done_i) begin
            throw_count_q <= throw_count_q + 8'd1;
            state_q       <= game_set_i ? StStop : StGap;
          end else if (game_set_i) begin
            state_q <= StStop;
          end else if (timer_q == 16'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= StError;
          end
        end
        StGap:   state_q <= StArm;
        default: state_q <= state_q;
      endcase
    end
  end

  assign busy_o            = (state_q == StArm) || (state_q == StFire) ||
                             (state_q == StWaitDone) || (state_q == StGap);
  assign dart_come_o       = dart_come_q;
  assign dart_position_x_o = pos_x_q;
  assign dart_position_y_o = pos_y_q;
  assign timeout_o         = timeout_q;
  assign throw_count_o     = throw_count_q;
  assign fifo_count_o      = count_q;

endmodule
